// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/TMP stage: opcodes, flag bit positions, FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_A = 2;
  localparam int unsigned FLAG_E = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StExec  = 2'd1,
    StWrite = 2'd2
  } state_e;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU: result, carry out and compare/zero flags.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] r_o,
  output logic             c_o,
  output logic             a_larger_o,
  output logic             eq_o,
  output logic             zero_o
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a_i} + {1'b0, b_i} + (WIDTH + 1)'(cin_i);

  // Opcode decode for result and carry out.
  always_comb begin
    r_o = '0;
    c_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        r_o = sum[WIDTH-1:0];
        c_o = sum[WIDTH];
      end
      OP_SHR: begin
        r_o = {cin_i, a_i[WIDTH-1:1]};
        c_o = a_i[0];
      end
      OP_SHL: begin
        r_o = {a_i[WIDTH-2:0], cin_i};
        c_o = a_i[WIDTH-1];
      end
      OP_NOT:  r_o = ~a_i;
      OP_AND:  r_o = a_i & b_i;
      OP_OR:   r_o = a_i | b_i;
      OP_XOR:  r_o = a_i ^ b_i;
      OP_CMP:  r_o = a_i ^ b_i;
      default: r_o = '0;
    endcase
  end

  assign a_larger_o = (a_i > b_i);
  assign eq_o       = (a_i == b_i);
  assign zero_o     = (r_o == '0);

endmodule

// File: rtl/alu_tmp_stage.sv
// TMP register, ALU sequencing and flag register feeding the accumulator.
// Optional flag-clear input clf_i is present when ALU_CLF_EN is defined.
module alu_tmp_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] bus_in_i,
  input  logic             tmp_s_i,
  input  logic             bus1_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic             carry_en_i,
  input  logic             set_flags_i,
`ifdef ALU_CLF_EN
  input  logic             clf_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] acc_d_o,
  output logic             acc_s_o,
  output logic [3:0]       flags_o
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] tmp_q, a_q, b_q, res_q;
  logic [2:0]       op_q;
  logic             cin_q, sf_q, acc_s_q;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_a_larger, alu_eq, alu_zero;
  logic             launch;

  assign launch = (state_q == StIdle) && start_i;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .a_i        (a_q),
    .b_i        (b_q),
    .cin_i      (cin_q),
    .op_i       (op_q),
    .r_o        (alu_r),
    .c_o        (alu_c),
    .a_larger_o (alu_a_larger),
    .eq_o       (alu_eq),
    .zero_o     (alu_zero)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next state: one operation per IDLE visit, start elsewhere is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_o = (state_q == StExec) || (state_q == StWrite);
    done_o = (state_q == StWrite);
  end

  // TMP register loads from the bus in any state.
  always_ff @(posedge clk_i) begin
    if (reset_i)      tmp_q <= '0;
    else if (tmp_s_i) tmp_q <= bus_in_i;
  end

  // Operand snapshot at launch; cin uses the flag value from before the operation.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_ADD;
      cin_q <= 1'b0;
      sf_q  <= 1'b0;
    end else if (launch) begin
      a_q   <= bus1_i ? WIDTH'(1) : tmp_q;
      b_q   <= bus_in_i;
      op_q  <= op_i;
      cin_q <= flags_q[FLAG_C] & carry_en_i;
      sf_q  <= set_flags_i;
    end
  end

  // Result register and write strobe; CMP leaves the accumulator alone.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      res_q   <= '0;
      acc_s_q <= 1'b0;
    end else begin
      acc_s_q <= 1'b0;
      if (state_q == StExec && op_q != OP_CMP) begin
        res_q   <= alu_r;
        acc_s_q <= 1'b1;
      end
    end
  end

  // Flag next state; a clear request overrides an EXEC write.
  always_comb begin
    flags_d = flags_q;
    if (state_q == StExec && sf_q) begin
      flags_d[FLAG_C] = alu_c;
      flags_d[FLAG_A] = alu_a_larger;
      flags_d[FLAG_E] = alu_eq;
      flags_d[FLAG_Z] = alu_zero;
    end
`ifdef ALU_CLF_EN
    if (clf_i) flags_d = '0;
`endif
  end

  // Flag register.
  always_ff @(posedge clk_i) begin
    if (reset_i) flags_q <= '0;
    else         flags_q <= flags_d;
  end

  assign acc_d_o = res_q;
  assign acc_s_o = acc_s_q;
  assign flags_o = flags_q;

endmodule

// File: tb/tb_alu_tmp_stage.sv
// Self-checking bench for alu_tmp_stage: directed cases plus randomized operations
// against an arithmetic reference model.
module tb_alu_tmp_stage;

  logic       clk = 1'b0;
  logic       reset, tmp_s, bus1, start, carry_en, set_flags;
  logic [7:0] bus_in;
  logic [2:0] op;
  logic       busy, done, acc_s;
  logic [7:0] acc_d;
  logic [3:0] flags;
`ifdef ALU_CLF_EN
  logic       clf;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] m_tmp   = 8'h00;
  logic [7:0] m_acc   = 8'h00;
  logic [3:0] m_flags = 4'h0;

  always #5 clk = ~clk;

  alu_tmp_stage #(
    .WIDTH (8)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .bus_in_i    (bus_in),
    .tmp_s_i     (tmp_s),
    .bus1_i      (bus1),
    .start_i     (start),
    .op_i        (op),
    .carry_en_i  (carry_en),
    .set_flags_i (set_flags),
`ifdef ALU_CLF_EN
    .clf_i       (clf),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .acc_d_o     (acc_d),
    .acc_s_o     (acc_s),
    .flags_o     (flags)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {C, A_larger, E, Z, result[7:0]} computed with plain integer arithmetic.
  function automatic logic [11:0] ref_alu(input int opc, input int a, input int b, input int cin);
    int r;
    int c;
    c = 0;
    case (opc)
      0: begin r = a + b + cin; c = (r > 255) ? 1 : 0; r = r % 256; end
      1: begin r = a / 2 + cin * 128; c = a % 2; end
      2: begin r = (a * 2 + cin) % 256; c = a / 128; end
      3: r = 255 - a;
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = a ^ b;
    endcase
    return {c[0], (a > b), (a == b), (r == 0), r[7:0]};
  endfunction

  task automatic load_tmp(input logic [7:0] v);
    @(negedge clk);
    bus_in = v;
    tmp_s  = 1'b1;
    @(negedge clk);
    tmp_s  = 1'b0;
    m_tmp  = v;
  endtask

  task automatic run_op(input logic [2:0] opc, input logic [7:0] b, input logic b1,
                        input logic cen, input logic sf);
    int          a;
    logic [11:0] e;
    a = b1 ? 1 : int'(m_tmp);
    e = ref_alu(int'(opc), a, int'(b), (cen && m_flags[3]) ? 1 : 0);
    @(negedge clk);
    start = 1'b1; op = opc; bus_in = b; bus1 = b1; carry_en = cen; set_flags = sf;
    @(negedge clk);
    start = 1'b0; bus_in = 8'($urandom); bus1 = 1'($urandom); carry_en = 1'($urandom);
    set_flags = 1'($urandom);
    chk("exec_busy", 8'(busy), 8'd1);
    chk("exec_acc_s", 8'(acc_s), 8'd0);
    if (sf) m_flags = e[11:8];
    if (opc != 3'd7) m_acc = e[7:0];
    @(negedge clk);
    chk("write_done", 8'(done), 8'd1);
    chk("write_acc_s", 8'(acc_s), (opc != 3'd7) ? 8'd1 : 8'd0);
    chk("write_acc_d", acc_d, m_acc);
    chk("write_flags", 8'(flags), 8'(m_flags));
    @(negedge clk);
    chk("idle_busy", 8'(busy), 8'd0);
    chk("idle_strobes", {6'd0, done, acc_s}, 8'd0);
  endtask

  initial begin
    logic [7:0] h;
    reset = 1'b1; tmp_s = 1'b0; bus1 = 1'b0; start = 1'b0; carry_en = 1'b0;
    set_flags = 1'b0; bus_in = 8'h00; op = 3'd0;
`ifdef ALU_CLF_EN
    clf = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_acc_s", 8'(acc_s), 8'd0);
    chk("rst_acc_d", acc_d, 8'h00);
    chk("rst_flags", 8'(flags), 8'h00);

    // 5 + 3 = 8, A_larger only.
    load_tmp(8'h05);
    run_op(3'd0, 8'h03, 1'b0, 1'b0, 1'b1);
    chk("add_const", acc_d, 8'h08);
    chk("add_flags_const", 8'(flags), 8'h04);

    // Wrap-around then carry-in.
    load_tmp(8'hFF);
    run_op(3'd0, 8'h01, 1'b0, 1'b0, 1'b1);
    chk("wrap_r", acc_d, 8'h00);
    chk("wrap_flags", 8'(flags), 8'h0D);
    load_tmp(8'h00);
    run_op(3'd0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("cin_add", acc_d, 8'h01);

    // Get C=1, then shifts of 0x81.
    load_tmp(8'h81);
    run_op(3'd0, 8'h80, 1'b0, 1'b0, 1'b1);
    run_op(3'd2, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("shl_r", acc_d, 8'h03);
    chk("shl_c", 8'(flags[3]), 8'd1);
    run_op(3'd1, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("shr_r", acc_d, 8'h40);
    chk("shr_c", 8'(flags[3]), 8'd1);

    // CMP equal: no accumulator write, E and Z set.
    load_tmp(8'h2A);
    run_op(3'd7, 8'h2A, 1'b0, 1'b0, 1'b1);
    chk("cmp_acc_d", acc_d, 8'h40);
    chk("cmp_flags", 8'(flags), 8'h03);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) load_tmp(8'($urandom));
      run_op(3'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
             1'($urandom));
    end

    // Start held high, TMP reloaded mid-operation, then bus1.
    load_tmp(8'h10);
    m_flags = 4'h0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; bus_in = 8'h01; bus1 = 1'b0; carry_en = 1'b0; set_flags = 1'b1;
    @(negedge clk);
    tmp_s = 1'b1; bus_in = 8'h77;
    chk("hold_exec_busy", 8'(busy), 8'd1);
    @(negedge clk);
    tmp_s = 1'b0; bus_in = 8'h02;
    chk("hold_snap_r", acc_d, 8'h11);
    chk("hold_snap_s", 8'(acc_s), 8'd1);
    @(negedge clk);
    chk("hold_idle", 8'(busy), 8'd0);
    @(negedge clk);
    chk("hold_second_busy", 8'(busy), 8'd1);
    @(negedge clk);
    chk("hold_second_r", acc_d, 8'h79);
    bus1 = 1'b1; bus_in = 8'h05;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0; bus1 = 1'b0;
    @(negedge clk);
    chk("bus1_r", acc_d, 8'h06);
    m_tmp = 8'h77; m_acc = 8'h06;
    h = 8'h06;
    @(negedge clk);

    // Reset during EXEC aborts the operation.
    @(negedge clk);
    start = 1'b1; op = 3'd3; bus_in = 8'h00; set_flags = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_acc_s", 8'(acc_s), 8'd0);
    chk("abort_flags", 8'(flags), 8'h00);
    chk("abort_acc_d", acc_d, h & 8'h00);
    m_tmp = 8'h00; m_acc = 8'h00; m_flags = 4'h0;

`ifdef ALU_CLF_EN
    // Clear request during EXEC beats the flag write; accumulator still written.
    load_tmp(8'h30);
    @(negedge clk);
    start = 1'b1; op = 3'd0; bus_in = 8'h01; set_flags = 1'b1; bus1 = 1'b0; carry_en = 1'b0;
    @(negedge clk);
    start = 1'b0; clf = 1'b1;
    @(negedge clk);
    clf = 1'b0;
    chk("clf_flags", 8'(flags), 8'h00);
    chk("clf_acc_d", acc_d, 8'h31);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_tmp_stage.md
Name: alu_tmp_stage

Overview:
- Upstream neighbour of the accumulator register: holds the TMP operand, performs the 8-bit ALU operation and updates the flag register (C, A-larger, E, Z).
- Drives the accumulator's data input and its set strobe.
- A start/busy/done handshake lets the control stepper launch one ALU operation at a time.
- The result reaches the accumulator through a registered write strobe.

Parameters:
- WIDTH, 8, data path width of the bus, TMP, ALU and result.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- bus_in  input  WIDTH  system bus; TMP load data and ALU B operand.
- tmp_s  input  1  set TMP: tmp <= bus_in at clock edge.
- bus1  input  1  when high at start, A operand is 1 instead of TMP.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  3  ALU opcode, sampled at start.
- carry_en  input  1  use stored C flag as carry-in, sampled at start.
- set_flags  input  1  update flag register with this operation's flags, sampled at start.
- busy  output  1  high in EXEC and WRITE.
- done  output  1  one-cycle pulse in WRITE.
- acc_d  output  WIDTH  result to accumulator d_in; holds its value between writes.
- acc_s  output  1  one-cycle accumulator set strobe.
- flags  output  4  registered {C, A_larger, E, Z}.

Behaviour:
- Reset (synchronous, active-high): tmp=0, flags=0, acc_d=0, acc_s=0, done=0, busy=0, state=IDLE. Reset mid-operation aborts: no acc_s and no flag update.
- TMP register:
  - tmp_s loads tmp in any state.
  - The A operand is snapshotted at start, so a TMP load during EXEC does not affect the running operation.
- FSM:
  - IDLE: on start, capture a_op = bus1 ? 1 : tmp, b_op = bus_in, op, carry_en and set_flags, then go to EXEC. Otherwise stay in IDLE.
  - EXEC: compute the result and flags; register the result into res_q; if set_flags was captured, write flags. Go to WRITE.
  - WRITE: done=1. acc_s=1 and acc_d=res_q, except for CMP, where acc_s=0 and acc_d is unchanged. Go to IDLE.
- Latency: start sampled at edge N; flags visible after edge N+1; acc_s and done high during the cycle after edge N+1 (one cycle wide).
- start while busy is ignored and is not queued. start asserted in the same cycle WRITE ends is also ignored; it is accepted on the following IDLE cycle.
- Carry-in: cin = flags.C & carry_en, using the stored flag from before the operation.
- Operations (unsigned, WIDTH bits):
  - 000 ADD: {C, r} = a + b + cin, carry out of the MSB.
  - 001 SHR: r = {cin, a[W-1:1]}, C = a[0].
  - 010 SHL: r = {a[W-2:0], cin}, C = a[W-1].
  - 011 NOT: r = ~a, C = 0.
  - 100 AND, 101 OR, 110 XOR: C = 0.
  - 111 CMP: r = a ^ b, C = 0, no accumulator write.
- Flags for every op:
  - A_larger = (a > b) unsigned.
  - E = (a == b).
  - Z = (r == 0).
- With set_flags=0 the flags hold their previous value.
- ADD wrap-around: 8'hFF + 8'h01 gives r = 0, C = 1, Z = 1.

Optional Feature:
- Macro: ALU_CLF_EN.
- Defined:
  - Adds input port clf (1 bit). clf high clears flags to 0 at the next edge in any state.
  - If clf and an EXEC flag write coincide, clf wins.
  - clf does not affect an in-flight operation's cin, which was captured at start.
- Undefined: no clf port; flags change only via reset or a set_flags operation.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD..OP_CMP;
  - flag bit indices FLAG_C=3, FLAG_A=2, FLAG_E=1, FLAG_Z=0;
  - FSM state encoding IDLE/EXEC/WRITE.
- One natural sub-module: alu_comb, the purely combinational ALU (a, b, cin, op -> r, c_out, a_larger, eq, zero), instantiated in alu_tmp_stage.
- TMP, FSM, flag and result registers stay in the top module.

Test Plan:
- Reset, then tmp_s with bus_in=8'h05, then start with op=ADD, bus_in=8'h03, set_flags=1 -> after 2 cycles acc_s=1 for one cycle, acc_d=8'h08, flags=4'b0100 (A_larger set).
- tmp=8'hFF, start ADD with b=8'h01, set_flags=1, then second ADD with carry_en=1, tmp=0, b=0 -> first result 0 with flags C=1, Z=1; second result 8'h01.
- tmp=8'h81, start SHL with carry_en=1 and stored C=1 -> acc_d=8'h03, C=1. Then SHR on the same operand with carry_en=0 -> acc_d=8'h40, C=1.
- tmp=8'h2A, start CMP with b=8'h2A -> done pulses, acc_s stays 0, acc_d unchanged, flags E=1, Z=1, A_larger=0.
- start held high continuously plus tmp_s mid-operation -> one operation per IDLE visit; the result uses the tmp snapshot; bus1=1 gives a=8'h01.
- Reset asserted during EXEC -> no acc_s, flags=0, busy=0 next cycle. With ALU_CLF_EN defined, clf during EXEC with set_flags=1 -> flags=0.
